// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner.
// Key codes are packed as row*COLS + col.
package keypad_pkg;

  localparam int ROWS   = 4;
  localparam int COLS   = 4;
  localparam int CODE_W = 4;

  typedef enum logic [1:0] {
    SCAN,
    CONFIRM,
    PRESSED,
    RELEASE
  } state_e;

  function automatic logic [CODE_W-1:0] pack_code(input logic [1:0] row,
                                                   input logic [1:0] col);
    return CODE_W'(int'(row) * COLS + int'(col));
  endfunction

endpackage

// File: rtl/keypad_sync.sv
// Two-flop synchronizer for asynchronous level inputs.
// Resets to all ones so idle (pulled-up) rows read as released.
module keypad_sync #(
  parameter int WIDTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= '1;
      sync_q <= '1;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/keypad_scanner.sv
// Column-scanning 4x4 keypad reader with press/release debounce and a
// one-entry code buffer. Handshake: key_valid_o stays high until key_ack_i is
// sampled high at a clock edge; an ack while key_valid_o is low is ignored.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV       = 1000,
  parameter int DEBOUNCE_TICKS = 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [ROWS-1:0]   rows_i,
  output logic [COLS-1:0]   cols_o,
  output logic [CODE_W-1:0] key_code_o,
  output logic              key_valid_o,
  input  logic              key_ack_i,
  output logic              overrun_o,
  output logic              key_down_o,
  output state_e            state_o
);

  localparam int PW = $clog2(SCAN_DIV);
  localparam int CW = $clog2(DEBOUNCE_TICKS);
  localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);
  // Compared before the increment, so the move happens as cnt reaches DEBOUNCE_TICKS-1.
  localparam logic [CW-1:0] CNT_LAST   = CW'(DEBOUNCE_TICKS - 2);

  logic [ROWS-1:0]   rs;
  logic [PW-1:0]     presc_q, presc_d;
  logic [1:0]        col_q, col_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  state_e            state_q, state_d;
  logic [1:0]        cand_row_q, cand_row_d;
  logic [CODE_W-1:0] code_q, code_d;
  logic              valid_q, valid_d;
  logic              ovr_q, ovr_d;

  logic       tick;
  logic       hit;
  logic [1:0] row;
  logic       cand_alone;
  logic       cand_low;
  logic       load;

  keypad_sync #(.WIDTH(ROWS)) u_sync (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .d_i    (rows_i),
    .q_o    (rs)
  );

  assign tick       = (presc_q == PRESC_LAST);
  assign hit        = ~&rs;
  assign cand_alone = (rs == ~(4'b0001 << cand_row_q));
  assign cand_low   = ~rs[cand_row_q];

  // Lowest-numbered low row wins when several are low.
  always_comb begin
    row = '0;
    for (int i = ROWS - 1; i >= 0; i--) begin
      if (!rs[i]) row = 2'(i);
    end
  end

  always_comb begin
    presc_d    = tick ? '0 : presc_q + 1'b1;
    col_d      = col_q;
    cnt_d      = cnt_q;
    state_d    = state_q;
    cand_row_d = cand_row_q;
    load       = 1'b0;
    if (tick) begin
      case (state_q)
        SCAN: begin
          if (hit) begin
            cand_row_d = row;
            cnt_d      = '0;
            state_d    = CONFIRM;
          end else begin
            col_d = col_q + 2'd1;
          end
        end
        CONFIRM: begin
          if (cand_alone) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_LAST) begin
              load    = 1'b1;
              state_d = PRESSED;
            end
          end else begin
            state_d = SCAN;
            col_d   = col_q + 2'd1;
          end
        end
        PRESSED: begin
          if (!cand_low) begin
            cnt_d   = '0;
            state_d = RELEASE;
          end
        end
        RELEASE: begin
          if (&rs) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_LAST) begin
              state_d = SCAN;
              col_d   = col_q + 2'd1;
            end
          end else if (cand_low) begin
            state_d = PRESSED;
          end else begin
            // Another key on this column breaks the release run.
            cnt_d = '0;
          end
        end
        default: state_d = SCAN;
      endcase
    end
  end

  // A load consumes any pending code; overrun only when it was never acked.
  always_comb begin
    code_d  = code_q;
    valid_d = valid_q;
    ovr_d   = ovr_q;
    if (load) begin
      code_d  = pack_code(cand_row_q, col_q);
      valid_d = 1'b1;
      if (valid_q) ovr_d = ~key_ack_i;
    end else if (key_ack_i && valid_q) begin
      valid_d = 1'b0;
      ovr_d   = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      presc_q    <= '0;
      col_q      <= '0;
      cnt_q      <= '0;
      state_q    <= SCAN;
      cand_row_q <= '0;
      code_q     <= '0;
      valid_q    <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      presc_q    <= presc_d;
      col_q      <= col_d;
      cnt_q      <= cnt_d;
      state_q    <= state_d;
      cand_row_q <= cand_row_d;
      code_q     <= code_d;
      valid_q    <= valid_d;
      ovr_q      <= ovr_d;
    end
  end

  assign cols_o      = ~(4'b0001 << col_q);
  assign key_code_o  = code_q;
  assign key_valid_o = valid_q;
  assign overrun_o   = ovr_q;
  assign key_down_o  = (state_q == PRESSED) || (state_q == RELEASE);
  assign state_o     = state_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a physical key-matrix model drives the rows and a
// tick-level behavioural model predicts the buffer and column outputs.
module tb_keypad_scanner;
  import keypad_pkg::*;

  localparam int SCAN_DIV = 4;
  localparam int DEB      = 3;
  localparam int M_IDLE = 0, M_DEB = 1, M_HELD = 2, M_REL = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        key_ack = 1'b0;
  logic [3:0]  rows;
  logic [3:0]  cols;
  logic [3:0]  code;
  logic        valid, ovr, down;
  state_e      st;
  logic [15:0] keys = '0;

  int n_checks = 0;
  int n_pass   = 0;

  bit         m_valid, m_ovr;
  logic [3:0] m_code;
  int         m_mode, m_col, m_row, m_cnt, m_presc;
  logic [3:0] rot [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

  always #5 clk = ~clk;

  keypad_scanner #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE_TICKS(DEB)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .rows_i      (rows),
    .cols_o      (cols),
    .key_code_o  (code),
    .key_valid_o (valid),
    .key_ack_i   (key_ack),
    .overrun_o   (ovr),
    .key_down_o  (down),
    .state_o     (st)
  );

  // Key (r,c) pulls row r low while column c is driven low.
  always_comb begin
    rows = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !cols[c]) rows[r] = 1'b0;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [3:0] lows_at(input int c);
    logic [3:0] l;
    for (int r = 0; r < 4; r++) l[r] = keys[r*4+c];
    return l;
  endfunction

  function automatic logic [10:0] dut_vec();
    return {valid, ovr, down, code, cols};
  endfunction

  function automatic logic [10:0] exp_vec();
    logic [3:0] one;
    one = 4'b0001;
    return {m_valid, m_ovr, (m_mode >= M_HELD), m_code, ~(one << m_col)};
  endfunction

  function automatic bit will_load();
    logic [3:0] l;
    l = lows_at(m_col);
    return (m_presc == SCAN_DIV - 1) && (m_mode == M_DEB) && (m_cnt == DEB - 2)
           && ($countones(l) == 1) && l[m_row];
  endfunction

  task automatic model_reset();
    m_valid = 0; m_ovr = 0; m_code = '0;
    m_mode = M_IDLE; m_col = 0; m_row = 0; m_cnt = 0; m_presc = 0;
  endtask

  task automatic model_edge(input bit ack);
    bit ld;
    logic [3:0] l;
    ld = 0;
    if (m_presc == SCAN_DIV - 1) begin
      l = lows_at(m_col);
      case (m_mode)
        M_IDLE: begin
          if (l != 0) begin
            for (int r = 0; r < 4; r++) if (l[r]) begin m_row = r; break; end
            m_cnt = 0;
            m_mode = M_DEB;
          end else m_col = (m_col + 1) % 4;
        end
        M_DEB: begin
          if ($countones(l) == 1 && l[m_row]) begin
            m_cnt++;
            if (m_cnt == DEB - 1) begin ld = 1; m_mode = M_HELD; end
          end else begin
            m_mode = M_IDLE;
            m_col = (m_col + 1) % 4;
          end
        end
        M_HELD: if (!l[m_row]) begin m_cnt = 0; m_mode = M_REL; end
        default: begin
          if (l == 0) begin
            m_cnt++;
            if (m_cnt == DEB - 1) begin m_mode = M_IDLE; m_col = (m_col + 1) % 4; end
          end else if (l[m_row]) m_mode = M_HELD;
          else m_cnt = 0;
        end
      endcase
    end
    m_presc = (m_presc + 1) % SCAN_DIV;
    if (ld) begin
      if (m_valid) m_ovr = !ack;
      m_valid = 1;
      m_code = 4'(m_row * 4 + m_col);
    end else if (ack && m_valid) begin
      m_valid = 0;
      m_ovr = 0;
    end
  endtask

  task automatic cyc(input bit ack);
    key_ack = ack;
    @(posedge clk);
    model_edge(ack);
    @(negedge clk);
    key_ack = 1'b0;
  endtask

  task automatic set_keys(input logic [15:0] k);
    while (m_presc != 0) cyc(0);
    keys = k;
  endtask

  task automatic ticks(input int n);
    repeat (n * SCAN_DIV) cyc(0);
  endtask

  task automatic wait_code(input logic [3:0] c, input int max_cyc, output bit ok);
    ok = 0;
    for (int i = 0; i < max_cyc; i++) begin
      cyc(0);
      if (valid === 1'b1 && code === c) begin ok = 1; break; end
    end
  endtask

  task automatic test_reset();
    #1;
    n_checks++;
    if (dut_vec() !== {3'b000, 4'h0, 4'b1110})
      $display("FAIL reset_initial act=%h exp=%h", dut_vec(), {3'b000, 4'h0, 4'b1110});
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    set_keys(16'h0040);
    ticks(4);
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (dut_vec() !== {3'b000, 4'h0, 4'b1110})
      $display("FAIL reset_midpress act=%h exp=%h", dut_vec(), {3'b000, 4'h0, 4'b1110});
    else n_pass++;
    @(negedge clk);
    keys = '0;
    rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 5; i++) begin
      for (int p = 0; p < SCAN_DIV; p++) begin
        n_checks++;
        if (cols !== rot[i % 4])
          $display("FAIL reset_rotation step=%0d act=%b exp=%b", i, cols, rot[i % 4]);
        else n_pass++;
        cyc(0);
      end
    end
  endtask

  task automatic test_basic_press();
    bit ok;
    set_keys(16'h0040);
    wait_code(4'd6, 31, ok);
    n_checks++;
    if (!ok || {valid, down, code} !== {2'b11, 4'd6})
      $display("FAIL basic_code act=%b%b/%0d exp=11/6", valid, down, code);
    else n_pass++;
    ticks(3);
    n_checks++;
    if (cols !== 4'b1011 || dut_vec() !== exp_vec())
      $display("FAIL basic_frozen act=%h exp=%h", dut_vec(), exp_vec());
    else n_pass++;
    cyc(1);
    n_checks++;
    if (valid !== 1'b0) $display("FAIL basic_ack act=%b exp=0", valid);
    else n_pass++;
    set_keys('0);
    ticks(DEB + 2);
    n_checks++;
    if (down !== 1'b0 || dut_vec() !== exp_vec())
      $display("FAIL basic_release act=%h exp=%h", dut_vec(), exp_vec());
    else n_pass++;
  endtask

  task automatic test_bounce();
    bit ok;
    for (int i = 0; i < 12; i++) begin
      set_keys((i % 2 == 0) ? 16'h0008 : 16'h0000);
      ticks($urandom_range(1, 2));
      n_checks++;
      if (valid !== 1'b0 || dut_vec() !== exp_vec())
        $display("FAIL bounce_nocode act=%h exp=%h", dut_vec(), exp_vec());
      else n_pass++;
    end
    set_keys(16'h0008);
    wait_code(4'd3, 40, ok);
    n_checks++;
    if (!ok || dut_vec() !== exp_vec())
      $display("FAIL bounce_code act=%h exp=%h", dut_vec(), exp_vec());
    else n_pass++;
    cyc(1);
    set_keys('0);
    ticks(1);
    set_keys(16'h0008);
    ticks(4);
    n_checks++;
    if ({valid, down} !== 2'b01 || dut_vec() !== exp_vec())
      $display("FAIL bounce_glitch act=%h exp=%h", dut_vec(), exp_vec());
    else n_pass++;
    set_keys('0);
    ticks(DEB + 2);
  endtask

  task automatic test_overrun();
    bit ok;
    set_keys(16'h0020);
    wait_code(4'd5, 40, ok);
    n_checks++;
    if (!ok) $display("FAIL overrun_first act=%0d exp=5", code);
    else n_pass++;
    set_keys('0);
    ticks(DEB + 2);
    set_keys(16'h0400);
    wait_code(4'd10, 40, ok);
    n_checks++;
    if (!ok || {valid, ovr, code} !== {2'b11, 4'd10})
      $display("FAIL overrun_set act=%b%b/%0d exp=11/10", valid, ovr, code);
    else n_pass++;
    cyc(1);
    n_checks++;
    if ({valid, ovr} !== 2'b00) $display("FAIL overrun_ack act=%b%b exp=00", valid, ovr);
    else n_pass++;
    set_keys('0);
    ticks(DEB + 2);
  endtask

  task automatic test_ack_load();
    bit ok, hit_it;
    set_keys(16'h0200);
    wait_code(4'd9, 40, ok);
    set_keys('0);
    ticks(DEB + 2);
    set_keys(16'h1000);
    hit_it = 0;
    for (int i = 0; i < 60 && !hit_it; i++) begin
      hit_it = will_load();
      cyc(hit_it);
    end
    n_checks++;
    if (!hit_it || {valid, ovr, code} !== {2'b10, 4'd12})
      $display("FAIL ack_load act=%b%b/%0d exp=10/12", valid, ovr, code);
    else n_pass++;
    n_checks++;
    if (dut_vec() !== exp_vec()) $display("FAIL ack_load_model act=%h exp=%h", dut_vec(), exp_vec());
    else n_pass++;
    cyc(1);
    set_keys('0);
    ticks(DEB + 2);
  endtask

  task automatic test_multi_key();
    bit ok;
    set_keys(16'h0002);
    wait_code(4'd1, 40, ok);
    n_checks++;
    if (!ok) $display("FAIL multi_first act=%0d exp=1", code);
    else n_pass++;
    cyc(1);
    set_keys(16'h0202);
    ticks(3);
    n_checks++;
    if (st !== PRESSED || {valid, down} !== 2'b01 || dut_vec() !== exp_vec())
      $display("FAIL multi_add act=%h exp=%h", dut_vec(), exp_vec());
    else n_pass++;
    set_keys(16'h0200);
    ticks(3);
    n_checks++;
    if (dut_vec() !== exp_vec()) $display("FAIL multi_swap act=%h exp=%h", dut_vec(), exp_vec());
    else n_pass++;
    set_keys('0);
    ticks(DEB + 2);
    set_keys(16'h0202);
    ticks(12);
    n_checks++;
    if (dut_vec() !== exp_vec()) $display("FAIL multi_both act=%h exp=%h", dut_vec(), exp_vec());
    else n_pass++;
    set_keys('0);
    ticks(DEB + 2);
  endtask

  task automatic test_random();
    logic [15:0] k;
    int sel;
    for (int n = 0; n < 60; n++) begin
      sel = $urandom_range(0, 9);
      if (sel < 3) k = '0;
      else if (sel < 9) k = 16'h0001 << $urandom_range(0, 15);
      else k = (16'h0001 << $urandom_range(0, 15)) | (16'h0001 << $urandom_range(0, 15));
      set_keys(k);
      repeat ($urandom_range(1, 6)) begin
        for (int p = 0; p < SCAN_DIV; p++) cyc($urandom_range(0, 7) == 0);
        n_checks++;
        if (dut_vec() !== exp_vec())
          $display("FAIL random keys=%h act=%h exp=%h", k, dut_vec(), exp_vec());
        else n_pass++;
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_basic_press();
    test_bounce();
    test_overrun();
    test_ack_load();
    test_multi_key();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
